// File: rtl/video_stream_pkg.sv
// rtl/video_stream_pkg.sv - shared types, widths and parameter sanity check for the video stream source
package video_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int SETX_W = 11;
  localparam int SETY_W = 10;
  localparam int PIX_W  = 8;

  function automatic bit params_ok(input int hdisp, input int vdisp, input int hblank,
                                   input int vblank, input int clk_div);
    return (hdisp >= 1) && (hdisp < 2048) && (vdisp >= 1) && (vdisp < 1024) &&
           (hblank >= 1) && (vblank >= 1) && (clk_div >= 1);
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - pixel-slot divider and h/v raster counters
// Everything is held at zero while run_i is low, so a new RUN always starts at (0,0).
module video_timing_gen
  import video_stream_pkg::*;
#(
  parameter int IMG_HDISP = 1280,
  parameter int IMG_VDISP = 720,
  parameter int H_BLANK   = 160,
  parameter int V_BLANK   = 30,
  parameter int CLK_DIV   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_i,
  output logic              tick_o,
  output logic              active_o,
  output logic              vact_o,
  output logic              hact_o,
  output logic              wrap_o,
  output logic [SETX_W-1:0] hpos_o,
  output logic [SETY_W-1:0] vpos_o
);

  localparam int H_TOTAL = IMG_HDISP + H_BLANK;
  localparam int V_TOTAL = IMG_VDISP + V_BLANK;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [H_W-1:0]   h_cnt_q, h_cnt_d;
  logic [V_W-1:0]   v_cnt_q, v_cnt_d;
  logic             h_last, v_last;

  assign tick_o   = run_i && (div_q == DIV_W'(CLK_DIV - 1));
  assign h_last   = (h_cnt_q == H_W'(H_TOTAL - 1));
  assign v_last   = (v_cnt_q == V_W'(V_TOTAL - 1));
  assign vact_o   = (v_cnt_q < V_W'(IMG_VDISP));
  assign hact_o   = (h_cnt_q < H_W'(IMG_HDISP));
  assign active_o = tick_o && vact_o && hact_o;
  assign wrap_o   = tick_o && h_last && v_last;
  assign hpos_o   = SETX_W'(h_cnt_q);
  assign vpos_o   = SETY_W'(v_cnt_q);

  always_comb begin
    div_d   = div_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!run_i) begin
      div_d   = '0;
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (tick_o) begin
      div_d = '0;
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      div_q   <= div_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

endmodule

// File: rtl/video_stream_source.sv
// rtl/video_stream_source.sv - pixel stream transmitter fed from a show-ahead line FIFO
// Frames always run to completion; enable is only re-evaluated at the frame wrap.
module video_stream_source
  import video_stream_pkg::*;
#(
  parameter int IMG_HDISP = 1280,
  parameter int IMG_VDISP = 720,
  parameter int H_BLANK   = 160,
  parameter int V_BLANK   = 30,
  parameter int CLK_DIV   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [PIX_W-1:0]  fifo_data,
  output logic              fifo_rd_en,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic [PIX_W-1:0]  post_img_Y,
  output logic [SETX_W-1:0] post_setx,
  output logic [SETY_W-1:0] post_sety,
  output logic              underflow,
  input  logic              clr_underflow,
  output logic              frame_done
);

  if (!params_ok(IMG_HDISP, IMG_VDISP, H_BLANK, V_BLANK, CLK_DIV)) begin : g_param_check
    $error("video_stream_source: illegal raster/divider parameters");
  end

  state_t state_q, state_d;
  logic   run, tick, active, vact, hact, wrap, arm_entry, uf_set;
  logic [SETX_W-1:0] hpos;
  logic [SETY_W-1:0] vpos;

  logic              vsync_q, vsync_d, href_q, href_d, clken_q, clken_d;
  logic              uf_q, uf_d, done_q, done_d;
  logic [PIX_W-1:0]  y_q, y_d;
  logic [SETX_W-1:0] setx_q, setx_d;
  logic [SETY_W-1:0] sety_q, sety_d;

  assign run = (state_q == RUN);

  video_timing_gen #(
    .IMG_HDISP(IMG_HDISP),
    .IMG_VDISP(IMG_VDISP),
    .H_BLANK  (H_BLANK),
    .V_BLANK  (V_BLANK),
    .CLK_DIV  (CLK_DIV)
  ) u_timing (
    .clk     (clk),
    .rst     (rst),
    .run_i   (run),
    .tick_o  (tick),
    .active_o(active),
    .vact_o  (vact),
    .hact_o  (hact),
    .wrap_o  (wrap),
    .hpos_o  (hpos),
    .vpos_o  (vpos)
  );

  assign fifo_rd_en = run && active && !fifo_empty;
  assign arm_entry  = (state_q == IDLE) && enable;
  assign uf_set     = active && fifo_empty;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = ARM;
      ARM:     if (!enable) state_d = IDLE;
               else if (!fifo_empty) state_d = RUN;
      RUN:     if (wrap && !enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // vsync/href only move on ticks so they stay aligned with the strobes when CLK_DIV > 1.
  always_comb begin
    vsync_d = vsync_q;
    href_d  = href_q;
    clken_d = 1'b0;
    y_d     = y_q;
    setx_d  = '0;
    sety_d  = '0;
    if (!run) begin
      vsync_d = 1'b0;
      href_d  = 1'b0;
      y_d     = '0;
    end else begin
      clken_d = active;
      if (tick) begin
        vsync_d = vact;
        href_d  = vact && hact;
      end
      if (active) begin
        setx_d = hpos;
        sety_d = vpos;
        y_d    = fifo_rd_en ? fifo_data : '0;
      end
    end
    uf_d   = uf_set || (uf_q && !clr_underflow && !arm_entry);
    done_d = wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      clken_q <= 1'b0;
      y_q     <= '0;
      setx_q  <= '0;
      sety_q  <= '0;
      uf_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      clken_q <= clken_d;
      y_q     <= y_d;
      setx_q  <= setx_d;
      sety_q  <= sety_d;
      uf_q    <= uf_d;
      done_q  <= done_d;
    end
  end

  assign post_frame_vsync = vsync_q;
  assign post_frame_href  = href_q;
  assign post_frame_clken = clken_q;
  assign post_img_Y       = y_q;
  assign post_setx        = setx_q;
  assign post_sety        = sety_q;
  assign underflow        = uf_q;
  assign frame_done       = done_q;

endmodule
